text_status_ctl: RTL and testbench

Pixel-pipeline controller that overlays up to three status text fields (LEVEL, SCORE, LIVES) onto the VGA stream. It sequences the shared text-ROM address bus and one shared 8x16 font ROM across the fields. It sits between the timing/background stage and the final RGB output, and is the only block that drives `char_xy` for the status text ROMs. It delays all timing signals to match its pipeline latency.

---
 rtl/text_status_ctl_pkg.sv | 31 +++
 rtl/text_status_ctl_if.sv | 23 ++
 rtl/text_status_ctl_field_decode.sv | 39 +++
 rtl/text_status_ctl.sv | 182 ++++++++++++++++++
 tb/tb_text_status_ctl.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/text_status_ctl_pkg.sv
// Shared constants and types for the status-text overlay controller.
// The optional LEVEL blink feature is enabled with the TEXT_BLINK_EN macro.
package text_status_pkg;

  localparam int unsigned FONT_W     = 8;
  localparam int unsigned FONT_H     = 16;
  localparam int unsigned FIELD_COLS = 16;
  localparam int unsigned PIPE_LAT   = 4;
  localparam int unsigned FIELD_W    = FONT_W * FIELD_COLS;

  typedef enum logic [1:0] {
    FLD_NONE  = 2'd0,
    FLD_LVL   = 2'd1,
    FLD_SCORE = 2'd2,
    FLD_LIVES = 2'd3
  } fld_sel_e;

  localparam logic [6:0] SPACE_CODE = 7'h20;

  // One pixel's worth of timing plus background colour, carried down the pipe.
  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } vid_t;

endpackage

// File: rtl/text_status_ctl_if.sv
// Text-ROM / font-ROM side of the status-text controller.
// master = controller, slave = ROM side.
interface text_status_ctl_if;

  logic [7:0]  char_xy_out;
  logic [1:0]  fld_sel_out;
  logic [6:0]  code_lvl_in;
  logic [6:0]  code_score_in;
  logic [6:0]  code_lives_in;
  logic [10:0] font_addr_out;
  logic [7:0]  font_pixels_in;

  modport master (
    output char_xy_out, fld_sel_out, font_addr_out,
    input  code_lvl_in, code_score_in, code_lives_in, font_pixels_in
  );

  modport slave (
    input  char_xy_out, fld_sel_out, font_addr_out,
    output code_lvl_in, code_score_in, code_lives_in, font_pixels_in
  );

endinterface

// File: rtl/text_status_ctl_field_decode.sv
// Region decode for one 16x1-character text field anchored at (X, Y).
// Outputs are zero whenever the pixel lies outside the field.
module text_field_decode
  import text_status_pkg::*;
#(
  parameter int unsigned X = 16,
  parameter int unsigned Y = 8
) (
  input  logic [10:0] hcount,
  input  logic [10:0] vcount,
  output logic        hit,
  output logic [3:0]  col,
  output logic [2:0]  xoff,
  output logic [3:0]  line
);

  localparam logic [10:0] XL = 11'(X);
  localparam logic [10:0] YL = 11'(Y);
  localparam logic [10:0] FW = 11'(FIELD_W);
  localparam logic [10:0] FH = 11'(FONT_H);

  logic [10:0] dx;
  logic [10:0] dy;

  always_comb begin
    dx   = hcount - XL;
    dy   = vcount - YL;
    hit  = (hcount >= XL) && (dx < FW) && (vcount >= YL) && (dy < FH);
    col  = '0;
    xoff = '0;
    line = '0;
    if (hit) begin
      col  = dx[6:3];
      xoff = dx[2:0];
      line = dy[3:0];
    end
  end

endmodule

// File: rtl/text_status_ctl.sv
// Four-stage status-text overlay (LEVEL/SCORE/LIVES) over the VGA stream.
// Define TEXT_BLINK_EN to enable frame-counter based blinking of the LEVEL field.
module text_status_ctl
  import text_status_pkg::*;
#(
  parameter int unsigned LVL_X      = 16,
  parameter int unsigned LVL_Y      = 8,
  parameter int unsigned SCORE_X    = 16,
  parameter int unsigned SCORE_Y    = 32,
  parameter int unsigned LIVES_X    = 16,
  parameter int unsigned LIVES_Y    = 56,
  parameter logic [11:0] TEXT_COLOR = 12'hFFF
) (
  input  logic               pclk,
  input  logic               rst_n,
  input  logic [10:0]        hcount_in,
  input  logic [10:0]        vcount_in,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               hblnk_in,
  input  logic               vblnk_in,
  input  logic [11:0]        rgb_in,
  input  logic               lvl_blink_in,
  text_status_ctl_if.master  rom,
  output logic [10:0]        hcount_out,
  output logic [10:0]        vcount_out,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic               hblnk_out,
  output logic               vblnk_out,
  output logic [11:0]        rgb_out
);

  logic       hit_lvl, hit_score, hit_lives;
  logic [3:0] col_lvl, col_score, col_lives;
  logic [2:0] xoff_lvl, xoff_score, xoff_lives;
  logic [3:0] line_lvl, line_score, line_lives;

  text_field_decode #(.X(LVL_X), .Y(LVL_Y)) u_dec_lvl (
    .hcount(hcount_in), .vcount(vcount_in),
    .hit(hit_lvl), .col(col_lvl), .xoff(xoff_lvl), .line(line_lvl)
  );

  text_field_decode #(.X(SCORE_X), .Y(SCORE_Y)) u_dec_score (
    .hcount(hcount_in), .vcount(vcount_in),
    .hit(hit_score), .col(col_score), .xoff(xoff_score), .line(line_score)
  );

  text_field_decode #(.X(LIVES_X), .Y(LIVES_Y)) u_dec_lives (
    .hcount(hcount_in), .vcount(vcount_in),
    .hit(hit_lives), .col(col_lives), .xoff(xoff_lives), .line(line_lives)
  );

  vid_t        vin;
  vid_t        vid1_q, vid1_d, vid2_q, vid2_d, vid3_q, vid3_d, vid4_q, vid4_d;
  fld_sel_e    fld1_q, fld1_d, fld2_q, fld2_d, fld3_q, fld3_d;
  logic [7:0]  char_xy_q, char_xy_d;
  logic [3:0]  line1_q, line1_d;
  logic [2:0]  xoff1_q, xoff1_d, xoff2_q, xoff2_d, xoff3_q, xoff3_d;
  logic [10:0] font_addr_q, font_addr_d;
  logic [6:0]  code;
  logic        lvl_ok;

`ifdef TEXT_BLINK_EN
  logic [5:0]  frame_cnt_q, frame_cnt_d;
  logic        vblnk_prev_q, vblnk_prev_d;

  always_comb begin
    frame_cnt_d  = frame_cnt_q;
    vblnk_prev_d = vblnk_in;
    if (vblnk_in && !vblnk_prev_q) frame_cnt_d = frame_cnt_q + 6'd1;
    lvl_ok = hit_lvl && !(lvl_blink_in && frame_cnt_q[5]);
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q  <= '0;
      vblnk_prev_q <= 1'b0;
    end else begin
      frame_cnt_q  <= frame_cnt_d;
      vblnk_prev_q <= vblnk_prev_d;
    end
  end
`else
  logic unused_blink;
  assign unused_blink = lvl_blink_in;
  assign lvl_ok       = hit_lvl;
`endif

  always_comb begin
    vin.hcount = hcount_in;
    vin.vcount = vcount_in;
    vin.hsync  = hsync_in;
    vin.vsync  = vsync_in;
    vin.hblnk  = hblnk_in;
    vin.vblnk  = vblnk_in;
    vin.rgb    = rgb_in;

    // Stage 1: field select with LVL > SCORE > LIVES priority.
    fld1_d    = FLD_NONE;
    char_xy_d = '0;
    line1_d   = '0;
    xoff1_d   = '0;
    if (lvl_ok) begin
      fld1_d = FLD_LVL;   char_xy_d = {4'h0, col_lvl};   line1_d = line_lvl;   xoff1_d = xoff_lvl;
    end else if (hit_score) begin
      fld1_d = FLD_SCORE; char_xy_d = {4'h0, col_score}; line1_d = line_score; xoff1_d = xoff_score;
    end else if (hit_lives) begin
      fld1_d = FLD_LIVES; char_xy_d = {4'h0, col_lives}; line1_d = line_lives; xoff1_d = xoff_lives;
    end
    vid1_d = vin;

    // Stage 2: text-ROM code mux forms the font address.
    case (fld1_q)
      FLD_LVL:   code = rom.code_lvl_in;
      FLD_SCORE: code = rom.code_score_in;
      FLD_LIVES: code = rom.code_lives_in;
      default:   code = SPACE_CODE;
    endcase
    font_addr_d = {code, line1_q};
    fld2_d      = fld1_q;
    xoff2_d     = xoff1_q;
    vid2_d      = vid1_q;

    // Stage 3: wait out the synchronous font ROM read.
    fld3_d  = fld2_q;
    xoff3_d = xoff2_q;
    vid3_d  = vid2_q;

    // Stage 4: blanking beats glyph, glyph beats background.
    vid4_d = vid3_q;
    if (vid3_q.hblnk || vid3_q.vblnk)
      vid4_d.rgb = '0;
    else if (fld3_q != FLD_NONE && rom.font_pixels_in[3'd7 - xoff3_q])
      vid4_d.rgb = TEXT_COLOR;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vid1_q      <= '0;
      vid2_q      <= '0;
      vid3_q      <= '0;
      vid4_q      <= '0;
      fld1_q      <= FLD_NONE;
      fld2_q      <= FLD_NONE;
      fld3_q      <= FLD_NONE;
      char_xy_q   <= '0;
      line1_q     <= '0;
      xoff1_q     <= '0;
      xoff2_q     <= '0;
      xoff3_q     <= '0;
      font_addr_q <= '0;
    end else begin
      vid1_q      <= vid1_d;
      vid2_q      <= vid2_d;
      vid3_q      <= vid3_d;
      vid4_q      <= vid4_d;
      fld1_q      <= fld1_d;
      fld2_q      <= fld2_d;
      fld3_q      <= fld3_d;
      char_xy_q   <= char_xy_d;
      line1_q     <= line1_d;
      xoff1_q     <= xoff1_d;
      xoff2_q     <= xoff2_d;
      xoff3_q     <= xoff3_d;
      font_addr_q <= font_addr_d;
    end
  end

  assign rom.char_xy_out   = char_xy_q;
  assign rom.fld_sel_out   = fld1_q;
  assign rom.font_addr_out = font_addr_q;

  assign hcount_out = vid4_q.hcount;
  assign vcount_out = vid4_q.vcount;
  assign hsync_out  = vid4_q.hsync;
  assign vsync_out  = vid4_q.vsync;
  assign hblnk_out  = vid4_q.hblnk;
  assign vblnk_out  = vid4_q.vblnk;
  assign rgb_out    = vid4_q.rgb;

endmodule

// File: tb/tb_text_status_ctl.sv
// Bench for text_status_ctl: random pixel stream vs. a field-geometry reference model,
// plus directed boundary, overlap, blanking, reset and blink scenarios.
module tb_text_status_ctl;

  localparam int LX = 16, LY = 8, SX = 16, SY = 32, VX = 16, VY = 56;
  localparam logic [11:0] TC = 12'hFFF;

  logic        pclk, rst_n;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in, lvl_blink_in;
  logic [11:0] rgb_in;

  logic [10:0] hcount_out, vcount_out, o_hcount, o_vcount;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic        o_hsync, o_vsync, o_hblnk, o_vblnk;
  logic [11:0] rgb_out, o_rgb;

  logic [7:0]  font_mem [2048];

  text_status_ctl_if ifd ();
  text_status_ctl_if ifo ();

  text_status_ctl u_dut (
    .pclk(pclk), .rst_n(rst_n),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .lvl_blink_in(lvl_blink_in), .rom(ifd),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  text_status_ctl #(.SCORE_Y(8)) u_ovl (
    .pclk(pclk), .rst_n(rst_n),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .lvl_blink_in(lvl_blink_in), .rom(ifo),
    .hcount_out(o_hcount), .vcount_out(o_vcount),
    .hsync_out(o_hsync), .vsync_out(o_vsync), .hblnk_out(o_hblnk), .vblnk_out(o_vblnk),
    .rgb_out(o_rgb)
  );

  // Text ROMs: code depends on column only; font ROM is a 1-cycle synchronous read.
  assign ifd.code_lvl_in   = 7'h4C + 7'(ifd.char_xy_out[3:0]);
  assign ifd.code_score_in = 7'h30 + 7'(ifd.char_xy_out[3:0]);
  assign ifd.code_lives_in = 7'h60 + 7'(ifd.char_xy_out[3:0]);
  assign ifo.code_lvl_in   = 7'h4C + 7'(ifo.char_xy_out[3:0]);
  assign ifo.code_score_in = 7'h30 + 7'(ifo.char_xy_out[3:0]);
  assign ifo.code_lives_in = 7'h60 + 7'(ifo.char_xy_out[3:0]);

  always @(posedge pclk) begin
    ifd.font_pixels_in <= font_mem[ifd.font_addr_out];
    ifo.font_pixels_in <= font_mem[ifo.font_addr_out];
  end

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    logic [1:0]  fld;
    logic [7:0]  cxy;
    logic [10:0] addr;
    logic [11:0] rgb;
    logic [25:0] tim;
  } exp_t;

  exp_t ring [8];
  int   total = 0, bad = 0, cyc = 0;
  int   m_frames = 0;
  bit   m_prev_vb = 0;

  function automatic bit inside_fld(int h, int v, int x, int y);
    return (h >= x) && (h < x + 128) && (v >= y) && (v < y + 16);
  endfunction

  function automatic exp_t model(int h, int v, logic hs, logic vs, logic hb, logic vb,
                                 logic [11:0] rgb, bit lvl_off);
    exp_t e;
    int fld, dx, dy, code;
    fld = 0; dx = 0; dy = 0;
    if (!lvl_off && inside_fld(h, v, LX, LY)) begin fld = 1; dx = h - LX; dy = v - LY; end
    else if (inside_fld(h, v, SX, SY))        begin fld = 2; dx = h - SX; dy = v - SY; end
    else if (inside_fld(h, v, VX, VY))        begin fld = 3; dx = h - VX; dy = v - VY; end
    case (fld)
      1: code = 'h4C + dx / 8;
      2: code = 'h30 + dx / 8;
      3: code = 'h60 + dx / 8;
      default: code = 'h20;
    endcase
    e.fld  = 2'(fld);
    e.cxy  = (fld != 0) ? 8'(dx / 8) : 8'h00;
    e.addr = 11'(code * 16 + dy);
    e.tim  = {11'(h), 11'(v), hs, vs, hb, vb};
    if (hb || vb)                                         e.rgb = 12'h000;
    else if (fld != 0 && font_mem[e.addr][7 - (dx % 8)])  e.rgb = TC;
    else                                                  e.rgb = rgb;
    return e;
  endfunction

  task automatic cycle(int h, int v, logic hs, logic vs, logic hb, logic vb,
                       logic [11:0] rgb, logic blink);
    exp_t e;
    bit   off;
    hcount_in = 11'(h); vcount_in = 11'(v);
    hsync_in = hs; vsync_in = vs; hblnk_in = hb; vblnk_in = vb;
    rgb_in = rgb; lvl_blink_in = blink;
    off = 0;
`ifdef TEXT_BLINK_EN
    off = blink && (m_frames >= 32);
    if (vb && !m_prev_vb) m_frames = (m_frames + 1) % 64;
`endif
    m_prev_vb = vb;
    ring[cyc % 8] = model(h, v, hs, vs, hb, vb, rgb, off);
    @(posedge pclk); #1;
    e = ring[cyc % 8];
    total++;
    if (ifd.char_xy_out !== e.cxy || ifd.fld_sel_out !== e.fld) begin
      bad++;
      $display("FAIL stage1 cyc=%0d got cxy=%h fld=%0d want cxy=%h fld=%0d",
               cyc, ifd.char_xy_out, ifd.fld_sel_out, e.cxy, e.fld);
    end
    if (cyc >= 1) begin
      e = ring[(cyc - 1) % 8];
      total++;
      if (ifd.font_addr_out !== e.addr) begin
        bad++;
        $display("FAIL font_addr cyc=%0d got=%h want=%h", cyc, ifd.font_addr_out, e.addr);
      end
    end
    if (cyc >= 3) begin
      e = ring[(cyc - 3) % 8];
      total++;
      if (rgb_out !== e.rgb) begin
        bad++;
        $display("FAIL rgb cyc=%0d got=%h want=%h", cyc, rgb_out, e.rgb);
      end
      total++;
      if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} !== e.tim) begin
        bad++;
        $display("FAIL timing cyc=%0d got=%h want=%h", cyc,
                 {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}, e.tim);
      end
    end
    cyc++;
  endtask

  task automatic idle();
    cycle(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h5A5, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge pclk); #1;
    rst_n = 1'b1;
    m_frames = 0; m_prev_vb = 0; cyc = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    hcount_in = 11'd20; vcount_in = 11'd10; hsync_in = 1; vsync_in = 1;
    hblnk_in = 0; vblnk_in = 0; rgb_in = 12'hABC; lvl_blink_in = 0;
    repeat (2) @(negedge pclk);
    total++;
    if ({ifd.char_xy_out, ifd.fld_sel_out, ifd.font_addr_out, rgb_out, hcount_out, vcount_out,
         hsync_out, vsync_out, hblnk_out, vblnk_out} !== '0) begin
      bad++;
      $display("FAIL reset_state got cxy=%h fld=%0d addr=%h rgb=%h h=%0d want all zero",
               ifd.char_xy_out, ifd.fld_sel_out, ifd.font_addr_out, rgb_out, hcount_out);
    end
    @(posedge pclk); #1;
    rst_n = 1'b1;
    m_frames = 0; m_prev_vb = 0; cyc = 0;
  endtask

  task automatic test_lvl_origin();
    cycle(16, 8, 0, 0, 0, 0, 12'h111, 0);
    total++;
    if (ifd.char_xy_out !== 8'h00 || ifd.fld_sel_out !== 2'd1) begin
      bad++;
      $display("FAIL lvl_origin got cxy=%h fld=%0d want 00/1", ifd.char_xy_out, ifd.fld_sel_out);
    end
    idle();
    total++;
    if (ifd.font_addr_out !== 11'h4C0) begin
      bad++;
      $display("FAIL lvl_origin_addr got=%h want=4c0", ifd.font_addr_out);
    end
  endtask

  task automatic test_glyph();
    cycle(24, 13, 0, 0, 0, 0, 12'h123, 0);
    total++;
    if (ifd.char_xy_out !== 8'h01) begin
      bad++;
      $display("FAIL glyph_cxy got=%h want=01", ifd.char_xy_out);
    end
    idle();
    total++;
    if (ifd.font_addr_out[3:0] !== 4'h5) begin
      bad++;
      $display("FAIL glyph_line got=%h want=5", ifd.font_addr_out[3:0]);
    end
    idle(); idle();
    total++;
    if (rgb_out !== 12'hFFF) begin
      bad++;
      $display("FAIL glyph_rgb got=%h want=fff", rgb_out);
    end
  endtask

  task automatic test_boundary();
    int pts [5][3] = '{'{143, 8, 1}, '{144, 8, 0}, '{16, 24, 0}, '{16, 23, 1}, '{15, 8, 0}};
    for (int i = 0; i < 5; i++) begin
      cycle(pts[i][0], pts[i][1], 0, 0, 0, 0, 12'h0F0, 0);
      total++;
      if (ifd.fld_sel_out !== 2'(pts[i][2])) begin
        bad++;
        $display("FAIL boundary (%0d,%0d) got fld=%0d want=%0d",
                 pts[i][0], pts[i][1], ifd.fld_sel_out, pts[i][2]);
      end
    end
    repeat (3) idle();
  endtask

  task automatic test_overlap();
    cycle(20, 10, 0, 0, 0, 0, 12'h222, 0);
    total++;
    if (ifo.fld_sel_out !== 2'd1) begin
      bad++;
      $display("FAIL overlap_fld got=%0d want=1", ifo.fld_sel_out);
    end
    idle();
    total++;
    if (ifo.font_addr_out !== 11'h4C2) begin
      bad++;
      $display("FAIL overlap_addr got=%h want=4c2", ifo.font_addr_out);
    end
  endtask

  task automatic test_blank();
    cycle(24, 13, 0, 0, 1, 0, 12'h777, 0);
    idle(); idle(); idle();
    total++;
    if (rgb_out !== 12'h000) begin
      bad++;
      $display("FAIL blank_rgb got=%h want=000", rgb_out);
    end
  endtask

  task automatic test_midreset();
    cycle(30, 12, 1, 0, 0, 0, 12'h333, 0);
    cycle(31, 12, 1, 0, 0, 0, 12'h333, 0);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({ifd.char_xy_out, ifd.fld_sel_out, ifd.font_addr_out, rgb_out, hcount_out, hsync_out} !== '0) begin
      bad++;
      $display("FAIL midreset_clear got cxy=%h fld=%0d addr=%h rgb=%h h=%0d want all zero",
               ifd.char_xy_out, ifd.fld_sel_out, ifd.font_addr_out, rgb_out, hcount_out);
    end
    @(posedge pclk); #1;
    rst_n = 1'b1;
    m_frames = 0; m_prev_vb = 0; cyc = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(40 + i, 14, 1, 1, 0, 0, 12'h9C9, 0);
      total++;
      if (rgb_out !== 12'h000 || hcount_out !== 11'd0) begin
        bad++;
        $display("FAIL midreset_flush i=%0d got rgb=%h h=%0d want 0/0", i, rgb_out, hcount_out);
      end
    end
    repeat (3) idle();
  endtask

  task automatic test_blink();
    logic [1:0] want;
`ifdef TEXT_BLINK_EN
    want = 2'd0;
`else
    want = 2'd1;
`endif
    do_reset();
    for (int k = 0; k < 32; k++) begin
      cycle(0, 0, 0, 0, 0, 1, 12'h000, 1);
      cycle(0, 0, 0, 0, 0, 0, 12'h000, 1);
    end
    cycle(20, 10, 0, 0, 0, 0, 12'h444, 1);
    total++;
    if (ifd.fld_sel_out !== want) begin
      bad++;
      $display("FAIL blink_32 got fld=%0d want=%0d", ifd.fld_sel_out, want);
    end
    for (int k = 0; k < 32; k++) begin
      cycle(0, 0, 0, 0, 0, 1, 12'h000, 1);
      cycle(0, 0, 0, 0, 0, 0, 12'h000, 1);
    end
    cycle(20, 10, 0, 0, 0, 0, 12'h444, 1);
    total++;
    if (ifd.fld_sel_out !== 2'd1) begin
      bad++;
      $display("FAIL blink_64 got fld=%0d want=1", ifd.fld_sel_out);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++)
      cycle($urandom_range(0, 200), $urandom_range(0, 100), 1'($urandom), 1'($urandom),
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0),
            12'($urandom), 1'($urandom));
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) font_mem[a] = 8'($urandom);
    font_mem[11'h4D5] = 8'h80;
    test_reset();
    test_lvl_origin();
    test_glyph();
    test_boundary();
    test_overlap();
    test_blank();
    test_midreset();
    test_random();
    test_blink();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
